// File: rtl/heichips25_dac_sequencer_pkg.sv
// Shared types and helpers for the DAC sequencer.
// Modes, sweep FSM states, thermometer encoding.
package heichips25_dac_pkg;

  typedef enum logic [1:0] {
    RAW   = 2'b00,
    THERM = 2'b01,
    SAW   = 2'b10,
    TRI   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } sweep_state_e;

  // Widest array the thermometer helper can encode;
  // callers slice the low N_CELLS bits.
  localparam int unsigned THERM_MAX = 1024;

  function automatic logic [31:0] sat(
    input logic [31:0] code,
    input logic [31:0] n
  );
    return (code > n) ? n : code;
  endfunction

  // Lowest min(code, n) bits set.
  function automatic logic [THERM_MAX-1:0] therm(
    input logic [31:0] code,
    input logic [31:0] n
  );
    logic [THERM_MAX-1:0] v;
    logic [31:0]          c;
    c = sat(code, n);
    v = '0;
    for (int unsigned i = 0; i < THERM_MAX; i++) begin
      v[i] = (i < c);
    end
    return v;
  endfunction

endpackage

// File: rtl/heichips25_dac_sequencer_sweep_gen.sv
// Sweep generator: FSM, step divider, code counter, wrap pulse.
// Ports: mode/start/stop/step_div/limit in; next code, update strobe, busy, wrap out.
module dac_sweep_gen
  import heichips25_dac_pkg::*;
#(
  parameter int CODE_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [DIV_W-1:0]  step_div_i,
  input  logic [CODE_W-1:0] limit_i,
  output logic [CODE_W-1:0] code_o,
  output logic              upd_o,
  output logic              busy_o,
  output logic              wrap_o
);

  sweep_state_e      r_state;
  sweep_state_e      w_state_nxt;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] w_code_nxt;
  logic [CODE_W-1:0] r_lim;
  logic [CODE_W-1:0] w_lim_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  w_div_nxt;
  logic [DIV_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  w_cnt_nxt;
  logic              r_wrap;
  logic              w_wrap_nxt;
  logic              w_upd;
  logic              w_sweep_mode;
  logic              w_step;

  assign w_sweep_mode = (mode_i == SAW) || (mode_i == TRI);
  assign w_step       = (r_cnt == r_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_code  <= '0;
      r_lim   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_lim   <= w_lim_nxt;
      r_div   <= w_div_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_lim_nxt   = r_lim;
    w_div_nxt   = r_div;
    w_cnt_nxt   = r_cnt;
    w_wrap_nxt  = 1'b0;
    w_upd       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i && !stop_i && w_sweep_mode) begin
          w_state_nxt = UP;
          w_code_nxt  = '0;
          w_cnt_nxt   = '0;
          w_div_nxt   = step_div_i;
          w_lim_nxt   = limit_i;
          w_upd       = 1'b1;
        end
      end
      UP: begin
        if (stop_i || !w_sweep_mode) begin
          w_state_nxt = IDLE;
        end else if (r_lim == '0) begin
          // Degenerate sweep: one busy cycle, no wrap.
          w_state_nxt = IDLE;
        end else if (!w_step) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end else begin
          w_cnt_nxt = '0;
          w_upd     = 1'b1;
          if (r_code != r_lim) begin
            w_code_nxt = r_code + 1'b1;
          end else if (mode_i == SAW || r_lim == 1) begin
            // TRI with L=1 turns at 0 straight away.
            w_code_nxt = '0;
            w_wrap_nxt = 1'b1;
          end else begin
            w_code_nxt  = r_lim - 1'b1;
            w_state_nxt = DOWN;
          end
        end
      end
      DOWN: begin
        if (stop_i || !w_sweep_mode) begin
          w_state_nxt = IDLE;
        end else if (!w_step) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end else begin
          w_cnt_nxt  = '0;
          w_upd      = 1'b1;
          w_code_nxt = r_code - 1'b1;
          if (r_code == 1) begin
            w_state_nxt = UP;
            w_wrap_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // code_o is the value the counter takes on the coming edge.
  assign code_o = w_code_nxt;
  assign upd_o  = w_upd;
  assign busy_o = (r_state != IDLE);
  assign wrap_o = r_wrap;

endmodule

// File: rtl/heichips25_dac_sequencer.sv
// DAC sequencer top: serial chain, shadow state, thermometer load, sweep.
// Ports: chain/transfer controls, mode, sweep controls, enable in; cells, taps, status out.
module heichips25_dac_sequencer
  import heichips25_dac_pkg::*;
#(
  parameter int N_CELLS = 128,
  parameter int CODE_W  = $clog2(N_CELLS + 1),
  parameter int DIV_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               datum_i,
  input  logic               shift_i,
  input  logic               transfer_i,
  input  logic               dir_i,
  input  logic [1:0]         mode_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [DIV_W-1:0]   step_div_i,
  input  logic               en_i,
  output logic [N_CELLS-1:0] on_o,
  output logic [N_CELLS-1:0] onb_o,
  output logic               en_o,
  output logic               enb_o,
  output logic [7:0]         chain_tap_o,
  output logic [7:0]         state_tap_o,
  output logic               busy_o,
  output logic               wrap_o
);

  logic [N_CELLS-1:0] r_chain;
  logic [N_CELLS-1:0] r_state;
  logic               r_en;
  logic               r_enb;

  logic [CODE_W-1:0]  w_limit;
  logic [CODE_W-1:0]  w_code;
  logic               w_upd;
  logic               w_busy;
  logic               w_wrap;
  logic [N_CELLS-1:0] w_therm_ld;
  logic [N_CELLS-1:0] w_therm_sw;
  logic               w_xfer;

  assign w_limit = CODE_W'(sat(32'(r_chain[CODE_W-1:0]), 32'(N_CELLS)));

  assign w_therm_ld = N_CELLS'(therm(32'(r_chain[CODE_W-1:0]),
                                     32'(N_CELLS)));
  assign w_therm_sw = N_CELLS'(therm(32'(w_code), 32'(N_CELLS)));

  // Chain/state access only while the sweep is parked.
  assign w_xfer = !w_busy && transfer_i;

  dac_sweep_gen #(
    .CODE_W (CODE_W),
    .DIV_W  (DIV_W)
  ) u_sweep (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_i     (mode_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .step_div_i (step_div_i),
    .limit_i    (w_limit),
    .code_o     (w_code),
    .upd_o      (w_upd),
    .busy_o     (w_busy),
    .wrap_o     (w_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else if (w_xfer) begin
      if (!dir_i) r_chain <= r_state;
    end else if (!w_busy && shift_i) begin
      r_chain <= {r_chain[N_CELLS-2:0], datum_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
    end else if (w_upd) begin
      r_state <= w_therm_sw;
    end else if (w_xfer && dir_i) begin
      r_state <= (mode_i == THERM) ? w_therm_ld : r_chain;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en  <= 1'b0;
      r_enb <= 1'b1;
    end else begin
      r_en  <= en_i;
      r_enb <= ~en_i;
    end
  end

  assign on_o        = r_state;
  assign onb_o       = ~r_state;
  assign en_o        = r_en;
  assign enb_o       = r_enb;
  assign chain_tap_o = r_chain[N_CELLS-1 -: 8];
  assign state_tap_o = r_state[N_CELLS-1 -: 8];
  assign busy_o      = w_busy;
  assign wrap_o      = w_wrap;

endmodule

// File: tb/tb_heichips25_dac_sequencer.sv
// Self-checking bench for heichips25_dac_sequencer (N_CELLS=128).
// Scenario tasks with a queue of expected on_o/wrap/busy values.
module tb_heichips25_dac_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         datum_i;
  logic         shift_i;
  logic         transfer_i;
  logic         dir_i;
  logic [1:0]   mode_i;
  logic         start_i;
  logic         stop_i;
  logic [7:0]   step_div_i;
  logic         en_i;
  logic [127:0] on_o;
  logic [127:0] onb_o;
  logic         en_o;
  logic         enb_o;
  logic [7:0]   chain_tap_o;
  logic [7:0]   state_tap_o;
  logic         busy_o;
  logic         wrap_o;

  typedef struct {
    logic [127:0] on;
    logic         wrap;
    logic         busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  heichips25_dac_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .datum_i     (datum_i),
    .shift_i     (shift_i),
    .transfer_i  (transfer_i),
    .dir_i       (dir_i),
    .mode_i      (mode_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .step_div_i  (step_div_i),
    .en_i        (en_i),
    .on_o        (on_o),
    .onb_o       (onb_o),
    .en_o        (en_o),
    .enb_o       (enb_o),
    .chain_tap_o (chain_tap_o),
    .state_tap_o (state_tap_o),
    .busy_o      (busy_o),
    .wrap_o      (wrap_o)
  );

  function automatic logic [127:0] tb_therm(int c);
    logic [127:0] one;
    one = 128'd1;
    if (c >= 128) return '1;
    return (one << c) - one;
  endfunction

  function automatic int exp_code(int k, int l, int d, bit tri_m);
    int s, p;
    s = k / (d + 1);
    if (!tri_m) return s % (l + 1);
    p = s % (2 * l);
    return (p <= l) ? p : 2 * l - p;
  endfunction

  function automatic bit exp_wrap(int k, int l, int d, bit tri_m);
    int per;
    per = tri_m ? 2 * l * (d + 1) : (l + 1) * (d + 1);
    return (k > 0) && (k % per == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_in(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      datum_i = v[i];
      shift_i = 1'b1;
      tick();
    end
    shift_i = 1'b0;
    datum_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (on_o !== 128'd0 || onb_o !== {128{1'b1}}) begin
      n_fail++;
      $display("FAIL reset_on on=%h onb=%h want 0/ones", on_o, onb_o);
    end
    n_checks++;
    if ({en_o, enb_o, busy_o, wrap_o} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0100",
               {en_o, enb_o, busy_o, wrap_o});
    end
    n_checks++;
    if (chain_tap_o !== 8'h00 || state_tap_o !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_taps got %h/%h want 00/00",
               chain_tap_o, state_tap_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_enable();
    en_i = 1'b1;
    #2;
    n_checks++;
    if (en_o !== 1'b0 || enb_o !== 1'b1) begin
      n_fail++;
      $display("FAIL en_early got %b%b want 01", en_o, enb_o);
    end
    tick();
    n_checks++;
    if (en_o !== 1'b1 || enb_o !== 1'b0) begin
      n_fail++;
      $display("FAIL en_rise got %b%b want 10", en_o, enb_o);
    end
    en_i = 1'b0;
    tick();
    n_checks++;
    if (en_o !== 1'b0 || enb_o !== 1'b1) begin
      n_fail++;
      $display("FAIL en_fall got %b%b want 01", en_o, enb_o);
    end
  endtask

  task automatic test_raw();
    logic [127:0] pat;
    exp_t e;
    pat = {16{8'hA5}};
    mode_i = 2'b00;
    shift_in(pat, 128);
    n_checks++;
    if (chain_tap_o !== 8'hA5) begin
      n_fail++;
      $display("FAIL raw_chain_tap got %h want a5", chain_tap_o);
    end
    sb.push_back('{on: pat, wrap: 1'b0, busy: 1'b0});
    transfer_i = 1'b1;
    dir_i      = 1'b1;
    tick();
    transfer_i = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (on_o !== e.on || onb_o !== ~e.on) begin
      n_fail++;
      $display("FAIL raw_load on=%h want %h", on_o, e.on);
    end
    n_checks++;
    if (state_tap_o !== 8'hA5) begin
      n_fail++;
      $display("FAIL raw_state_tap got %h want a5", state_tap_o);
    end
    shift_in(128'd0, 128);
    n_checks++;
    if (chain_tap_o !== 8'h00) begin
      n_fail++;
      $display("FAIL raw_zero_tap got %h want 00", chain_tap_o);
    end
    // Transfer must win over a simultaneous shift.
    transfer_i = 1'b1;
    dir_i      = 1'b0;
    shift_i    = 1'b1;
    datum_i    = 1'b1;
    tick();
    transfer_i = 1'b0;
    shift_i    = 1'b0;
    datum_i    = 1'b0;
    n_checks++;
    if (chain_tap_o !== 8'hA5) begin
      n_fail++;
      $display("FAIL raw_readback got %h want a5", chain_tap_o);
    end
  endtask

  task automatic test_therm();
    int codes [5] = '{5, 255, 128, 127, 0};
    exp_t e;
    mode_i = 2'b01;
    foreach (codes[i]) begin
      shift_in(128'(codes[i]), 8);
      sb.push_back('{on: tb_therm(codes[i]), wrap: 1'b0, busy: 1'b0});
      transfer_i = 1'b1;
      dir_i      = 1'b1;
      tick();
      transfer_i = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if (on_o !== e.on || onb_o !== ~e.on) begin
        n_fail++;
        $display("FAIL therm_%0d on=%h want %h", codes[i], on_o, e.on);
      end
    end
  endtask

  task automatic test_saw();
    int   l = 3;
    int   d = 1;
    exp_t e;
    mode_i = 2'b10;
    shift_in({8'hFF, 112'd0, 8'd3}, 128);
    step_div_i = 8'(d);
    for (int k = 0; k <= 20; k++) begin
      sb.push_back('{on: tb_therm(exp_code(k, l, d, 1'b0)),
                     wrap: exp_wrap(k, l, d, 1'b0), busy: 1'b1});
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    shift_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      start_i = (k == 5);
      e = sb.pop_front();
      n_checks++;
      if (on_o !== e.on || wrap_o !== e.wrap || busy_o !== e.busy) begin
        n_fail++;
        $display("FAIL saw_k%0d on=%h w=%b b=%b want %h/%b/%b",
                 k, on_o, wrap_o, busy_o, e.on, e.wrap, e.busy);
      end
      n_checks++;
      if (chain_tap_o !== 8'hFF) begin
        n_fail++;
        $display("FAIL saw_shift_k%0d tap=%h want ff", k, chain_tap_o);
      end
      tick();
    end
    start_i = 1'b0;
    shift_i = 1'b0;
    e = sb.pop_front();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0 || on_o !== e.on || wrap_o !== 1'b0) begin
      n_fail++;
      $display("FAIL saw_stop b=%b on=%h want 0/%h", busy_o, on_o, e.on);
    end
  endtask

  task automatic test_tri();
    int   l = 2;
    int   d = 0;
    exp_t e;
    mode_i = 2'b11;
    shift_in(128'd2, 8);
    step_div_i = 8'(d);
    for (int k = 0; k <= 13; k++) begin
      sb.push_back('{on: tb_therm(exp_code(k, l, d, 1'b1)),
                     wrap: exp_wrap(k, l, d, 1'b1), busy: 1'b1});
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 13; k++) begin
      e = sb.pop_front();
      n_checks++;
      if (on_o !== e.on || wrap_o !== e.wrap || busy_o !== e.busy) begin
        n_fail++;
        $display("FAIL tri_k%0d on=%h w=%b b=%b want %h/%b/%b",
                 k, on_o, wrap_o, busy_o, e.on, e.wrap, e.busy);
      end
      tick();
    end
    e = sb.pop_front();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0 || on_o !== e.on) begin
      n_fail++;
      $display("FAIL tri_stop b=%b on=%h want 0/%h", busy_o, on_o, e.on);
    end
    tick();
    n_checks++;
    if (on_o !== e.on) begin
      n_fail++;
      $display("FAIL tri_hold on=%h want %h", on_o, e.on);
    end
  endtask

  task automatic test_corners();
    exp_t e;
    mode_i     = 2'b10;
    step_div_i = 8'd0;
    shift_in(128'd0, 8);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b1 || on_o !== 128'd0 || wrap_o !== 1'b0) begin
      n_fail++;
      $display("FAIL l0_first b=%b w=%b on=%h want 1/0/0",
               busy_o, wrap_o, on_o);
    end
    tick();
    n_checks++;
    if (busy_o !== 1'b0 || on_o !== 128'd0 || wrap_o !== 1'b0) begin
      n_fail++;
      $display("FAIL l0_second b=%b w=%b on=%h want 0/0/0",
               busy_o, wrap_o, on_o);
    end
    shift_in(128'd3, 8);
    start_i = 1'b1;
    stop_i  = 1'b1;
    tick();
    start_i = 1'b0;
    stop_i  = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_start b=%b want 0", busy_o);
    end
    sb.push_back('{on: tb_therm(exp_code(2, 3, 0, 1'b0)),
                   wrap: 1'b0, busy: 1'b0});
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mode_chg_start b=%b want 1", busy_o);
    end
    tick();
    tick();
    mode_i = 2'b00;
    tick();
    e = sb.pop_front();
    n_checks++;
    if (busy_o !== e.busy || on_o !== e.on) begin
      n_fail++;
      $display("FAIL mode_chg b=%b on=%h want %b/%h",
               busy_o, on_o, e.busy, e.on);
    end
  endtask

  task automatic test_async_reset();
    en_i       = 1'b1;
    mode_i     = 2'b11;
    step_div_i = 8'd0;
    shift_in(128'd5, 8);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    n_checks++;
    if (busy_o !== 1'b1 || en_o !== 1'b1 || on_o !== tb_therm(2)) begin
      n_fail++;
      $display("FAIL areset_pre b=%b en=%b on=%h want 1/1/%h",
               busy_o, en_o, on_o, tb_therm(2));
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (on_o !== 128'd0 || en_o !== 1'b0 || enb_o !== 1'b1 ||
        busy_o !== 1'b0 || wrap_o !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_now on=%h en=%b enb=%b b=%b want 0/0/1/0",
               on_o, en_o, enb_o, busy_o);
    end
    #1;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy_o !== 1'b0 || on_o !== 128'd0 || en_o !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_post b=%b on=%h en=%b want 0/0/1",
               busy_o, on_o, en_o);
    end
  endtask

  initial begin
    datum_i    = 1'b0;
    shift_i    = 1'b0;
    transfer_i = 1'b0;
    dir_i      = 1'b0;
    mode_i     = 2'b00;
    start_i    = 1'b0;
    stop_i     = 1'b0;
    step_div_i = 8'd0;
    en_i       = 1'b0;
    test_reset();
    test_enable();
    test_raw();
    test_therm();
    test_saw();
    test_tri();
    test_corners();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
